// File: rtl/cpm_fifo_pkg.sv
// Shared types, helpers and the lane-slicing macro for the CPM FIFO family.
// Defines CPM_LANE(vec, idx, w): word idx of a packed vector of w-bit words.
`ifndef CPM_FIFO_PKG_SV
`define CPM_FIFO_PKG_SV

`define CPM_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]

package cpm_fifo_pkg;

    typedef struct packed {
        logic ovf;
        logic udf;
    } cpm_fifo_err_t;

    // Callers cast the result down to their ADDR_WIDTH+1 count width.
    function automatic int num2cnt(input int x);
        return x + 1;
    endfunction

endpackage

`endif

// File: rtl/cpm_fifo_ptr.sv
// Wrapping pointer plus occupancy counter with variable increment/decrement.
// The pointer advances by the increment; the count moves by increment minus decrement.
module cpm_fifo_ptr
    import cpm_fifo_pkg::*;
#(
    parameter int AW      = 4,
    parameter int CW      = AW + 1,
    parameter int CNT_RST = 0
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          i_inc_en,
    input  logic [CW-1:0] i_inc_val,
    input  logic          i_dec_en,
    input  logic [CW-1:0] i_dec_val,
    output logic [AW-1:0] o_ptr,
    output logic [CW-1:0] o_cnt
);

    logic [AW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] w_ptr_next;
    logic [CW-1:0] w_cnt_next;

    always_comb begin
        w_ptr_next = r_ptr;
        w_cnt_next = r_cnt;
        if (i_inc_en) begin
            w_ptr_next = r_ptr + i_inc_val[AW-1:0];
            w_cnt_next = w_cnt_next + i_inc_val;
        end
        if (i_dec_en) begin
            w_cnt_next = w_cnt_next - i_dec_val;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_ptr <= '0;
            r_cnt <= CW'(CNT_RST);
        end else begin
            r_ptr <= w_ptr_next;
            r_cnt <= w_cnt_next;
        end
    end

    assign o_ptr = r_ptr;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/cpm_mimo_fifo.sv
// Multi-in/multi-out FIFO: 1..PUSH_MAX_N words in, 1..POP_MAX_N words out per cycle.
// Define CPM_MIMO_FIFO_REG_OUT_EN for a registered output; otherwise output is show-ahead.
module cpm_mimo_fifo
    import cpm_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int PUSH_NUMAW = 3,
    parameter int POP_NUMAW  = 2,
    parameter int PUSH_MAX_N = 1 << PUSH_NUMAW,
    parameter int POP_MAX_N  = 1 << POP_NUMAW,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             Reset,
    input  logic                             push,
    input  logic [PUSH_NUMAW-1:0]            push_num,
    input  logic [PUSH_MAX_N*DATA_WIDTH-1:0] data_in,
    output logic                             push_ready,
    input  logic                             pop,
    input  logic [POP_NUMAW-1:0]             pop_num,
    output logic                             pop_ready,
    output logic [POP_MAX_N*DATA_WIDTH-1:0]  data_out,
    output logic [POP_MAX_N-1:0]             data_out_vld,
    output logic                             empty,
    output logic                             full,
    output logic [ADDR_WIDTH:0]              fifo_count,
    output logic [ADDR_WIDTH:0]              fifo_count_empty,
    output logic                             err_ovf,
    output logic                             err_udf
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [CW-1:0]         w_push_cnt;
    logic [CW-1:0]         w_pop_cnt;
    logic                  w_push_ready;
    logic                  w_pop_ready;
    logic                  w_push_acc;
    logic                  w_pop_acc;
    logic [ADDR_WIDTH-1:0] w_wr_ptr;
    logic [ADDR_WIDTH-1:0] w_rd_ptr;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_free;
    cpm_fifo_err_t         r_err;

    assign w_push_cnt   = CW'(num2cnt(int'(push_num)));
    assign w_pop_cnt    = CW'(num2cnt(int'(pop_num)));
    // Readiness uses pre-cycle state only, so a same-cycle pop never frees space for a push.
    assign w_push_ready = (w_free >= w_push_cnt);
    assign w_pop_ready  = (w_count >= w_pop_cnt);
    assign w_push_acc   = push & w_push_ready;
    assign w_pop_acc    = pop & w_pop_ready;

    // Write side owns the occupancy count; read side owns the free count.
    cpm_fifo_ptr #(
        .AW      (ADDR_WIDTH),
        .CW      (CW),
        .CNT_RST (0)
    ) u_wr_ptr (
        .clk       (clk),
        .Reset     (Reset),
        .i_inc_en  (w_push_acc),
        .i_inc_val (w_push_cnt),
        .i_dec_en  (w_pop_acc),
        .i_dec_val (w_pop_cnt),
        .o_ptr     (w_wr_ptr),
        .o_cnt     (w_count)
    );

    cpm_fifo_ptr #(
        .AW      (ADDR_WIDTH),
        .CW      (CW),
        .CNT_RST (RAM_DEPTH)
    ) u_rd_ptr (
        .clk       (clk),
        .Reset     (Reset),
        .i_inc_en  (w_pop_acc),
        .i_inc_val (w_pop_cnt),
        .i_dec_en  (w_push_acc),
        .i_dec_val (w_push_cnt),
        .o_ptr     (w_rd_ptr),
        .o_cnt     (w_free)
    );

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0] w_wr_addr [PUSH_MAX_N];
    logic [PUSH_MAX_N-1:0] w_wr_en;
    logic [ADDR_WIDTH-1:0] w_rd_addr [POP_MAX_N];
    logic [DATA_WIDTH-1:0] w_rd_word [POP_MAX_N];

    generate
        for (genvar gi = 0; gi < PUSH_MAX_N; gi++) begin : g_wr_lane
            assign w_wr_addr[gi] = w_wr_ptr + ADDR_WIDTH'(gi);
            assign w_wr_en[gi]   = w_push_acc && (gi <= int'(push_num));
        end
        for (genvar gi = 0; gi < POP_MAX_N; gi++) begin : g_rd_lane
            assign w_rd_addr[gi] = w_rd_ptr + ADDR_WIDTH'(gi);
            assign w_rd_word[gi] = r_mem[w_rd_addr[gi]];
        end
    endgenerate

    // Storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_MAX_N; i++) begin
            if (w_wr_en[i]) begin
                r_mem[w_wr_addr[i]] <= `CPM_LANE(data_in, i, DATA_WIDTH);
            end
        end
    end

`ifdef CPM_MIMO_FIFO_REG_OUT_EN
    logic [POP_MAX_N*DATA_WIDTH-1:0] r_data_out;
    logic [POP_MAX_N-1:0]            r_data_out_vld;
    logic [POP_MAX_N-1:0]            w_pop_mask;

    generate
        for (genvar gi = 0; gi < POP_MAX_N; gi++) begin : g_pop_mask
            assign w_pop_mask[gi] = (gi <= int'(pop_num));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_data_out     <= '0;
            r_data_out_vld <= '0;
        end else if (w_pop_acc) begin
            for (int i = 0; i < POP_MAX_N; i++) begin
                `CPM_LANE(r_data_out, i, DATA_WIDTH) <= w_rd_word[i];
            end
            r_data_out_vld <= w_pop_mask;
        end
    end

    assign data_out     = r_data_out;
    assign data_out_vld = r_data_out_vld;
`else
    generate
        for (genvar gi = 0; gi < POP_MAX_N; gi++) begin : g_show_ahead
            assign `CPM_LANE(data_out, gi, DATA_WIDTH) = w_rd_word[gi];
            assign data_out_vld[gi] = (w_count > CW'(gi));
        end
    endgenerate
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_err <= '0;
        end else begin
            r_err.ovf <= r_err.ovf | (push & ~w_push_ready);
            r_err.udf <= r_err.udf | (pop & ~w_pop_ready);
        end
    end

    assign push_ready       = w_push_ready;
    assign pop_ready        = w_pop_ready;
    assign empty            = (w_count == '0);
    assign full             = (w_count == CW'(RAM_DEPTH));
    assign fifo_count       = w_count;
    assign fifo_count_empty = w_free;
    assign err_ovf          = r_err.ovf;
    assign err_udf          = r_err.udf;

endmodule

// File: tb/tb_cpm_mimo_fifo.sv
// Directed and random bench for cpm_mimo_fifo at default parameters (depth 16, 8-in, 4-out).
// Works in both output builds (CPM_MIMO_FIFO_REG_OUT_EN defined or not).
module tb_cpm_mimo_fifo;

    localparam int DW     = 64;
    localparam int DEPTH  = 16;
    localparam int PUSH_N = 8;
    localparam int POP_N  = 4;

    logic                   clk = 1'b0;
    logic                   Reset = 1'b1;
    logic                   push = 1'b0;
    logic [2:0]             push_num = '0;
    logic [PUSH_N*DW-1:0]   data_in = '0;
    logic                   push_ready;
    logic                   pop = 1'b0;
    logic [1:0]             pop_num = '0;
    logic                   pop_ready;
    logic [POP_N*DW-1:0]    data_out;
    logic [POP_N-1:0]       data_out_vld;
    logic                   empty;
    logic                   full;
    logic [4:0]             fifo_count;
    logic [4:0]             fifo_count_empty;
    logic                   err_ovf;
    logic                   err_udf;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] q[$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    cpm_mimo_fifo dut (
        .clk              (clk),
        .Reset            (Reset),
        .push             (push),
        .push_num         (push_num),
        .data_in          (data_in),
        .push_ready       (push_ready),
        .pop              (pop),
        .pop_num          (pop_num),
        .pop_ready        (pop_ready),
        .data_out         (data_out),
        .data_out_vld     (data_out_vld),
        .empty            (empty),
        .full             (full),
        .fifo_count       (fifo_count),
        .fifo_count_empty (fifo_count_empty),
        .err_ovf          (err_ovf),
        .err_udf          (err_udf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_status();
        check_val("fifo_count", 64'(fifo_count), 64'(q.size()));
        check_val("fifo_count_empty", 64'(fifo_count_empty), 64'(DEPTH - q.size()));
        check_val("empty", 64'(empty), 64'(q.size() == 0));
        check_val("full", 64'(full), 64'(q.size() == DEPTH));
        check_val("err_ovf", 64'(err_ovf), 64'(m_ovf));
        check_val("err_udf", 64'(err_udf), 64'(m_udf));
    endtask

    // One clock of stimulus; push words are base+i. Model decides acceptance from its own state.
    task automatic cycle(input logic ps, input int pn, input logic [63:0] base,
                         input logic pp, input int on);
        int   free;
        logic acc_push;
        logic acc_pop;
`ifdef CPM_MIMO_FIFO_REG_OUT_EN
        logic [63:0] popped [POP_N];
`endif
        free     = DEPTH - q.size();
        acc_push = ps && (free >= pn + 1);
        acc_pop  = pp && (q.size() >= on + 1);
        push     = ps;
        push_num = pn[2:0];
        for (int i = 0; i < PUSH_N; i++) data_in[i*DW +: DW] = base + 64'(i);
        pop      = pp;
        pop_num  = on[1:0];
        #1;
        check_val("push_ready", 64'(push_ready), 64'(free >= pn + 1));
        check_val("pop_ready", 64'(pop_ready), 64'(q.size() >= on + 1));
`ifdef CPM_MIMO_FIFO_REG_OUT_EN
        for (int i = 0; i < POP_N; i++) popped[i] = (i < q.size()) ? q[i] : 64'h0;
`else
        for (int i = 0; i < POP_N; i++) begin
            check_val("data_out_vld_bit", 64'(data_out_vld[i]), 64'(q.size() > i));
            if (i < q.size()) check_val("data_out_word", data_out[i*DW +: DW], q[i]);
        end
`endif
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        if (ps && !acc_push) m_ovf = 1'b1;
        if (pp && !acc_pop) m_udf = 1'b1;
        if (acc_pop) for (int i = 0; i <= on; i++) void'(q.pop_front());
        if (acc_push) for (int i = 0; i <= pn; i++) q.push_back(base + 64'(i));
`ifdef CPM_MIMO_FIFO_REG_OUT_EN
        if (acc_pop) begin
            for (int i = 0; i < POP_N; i++) begin
                check_val("reg_vld_bit", 64'(data_out_vld[i]), 64'(i <= on));
                if (i <= on) check_val("reg_data_word", data_out[i*DW +: DW], popped[i]);
            end
        end
`endif
        check_status();
        $display("txn t=%0t push=%0b n=%0d pop=%0b n=%0d acc=%0b%0b count=%0d",
                 $time, ps, pn + 1, pp, on + 1, acc_push, acc_pop, q.size());
    endtask

    task automatic do_reset(input logic with_push);
        Reset    = 1'b1;
        push     = with_push;
        push_num = 3'd0;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        push  = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_status();
        $display("txn t=%0t reset push_active=%0b count=%0d", $time, with_push, fifo_count);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        Reset = 1'b0;
        #1;
        // Reset state
        check_val("rst_count", 64'(fifo_count), 64'd0);
        check_val("rst_empty", 64'(empty), 64'd1);
        check_val("rst_full", 64'(full), 64'd0);
        check_val("rst_free", 64'(fifo_count_empty), 64'd16);
        check_val("rst_push_ready", 64'(push_ready), 64'd1);
        check_val("rst_pop_ready", 64'(pop_ready), 64'd0);
        check_val("rst_vld", 64'(data_out_vld), 64'd0);
        check_val("rst_err", 64'({err_ovf, err_udf}), 64'd0);

        // Fill to full, then an overflowing push
        cycle(1'b1, 7, 64'd0, 1'b0, 0);
        cycle(1'b1, 7, 64'd8, 1'b0, 0);
        check_val("full_set", 64'(full), 64'd1);
        check_val("full_count", 64'(fifo_count), 64'd16);
`ifndef CPM_MIMO_FIFO_REG_OUT_EN
        check_val("full_lane3", data_out[3*DW +: DW], 64'd3);
`endif
        cycle(1'b1, 0, 64'h99, 1'b0, 0);
        check_val("ovf_sticky", 64'(err_ovf), 64'd1);
        check_val("ovf_count_hold", 64'(fifo_count), 64'd16);
        do_reset(1'b0);
        check_val("ovf_cleared", 64'(err_ovf), 64'd0);

        // Underflowing pop, then exact drain
        cycle(1'b1, 2, 64'd0, 1'b0, 0);
        cycle(1'b0, 0, 64'd0, 1'b1, 3);
        check_val("udf_set", 64'(err_udf), 64'd1);
        check_val("udf_count_hold", 64'(fifo_count), 64'd3);
        cycle(1'b0, 0, 64'd0, 1'b1, 2);
        check_val("drain_empty", 64'(empty), 64'd1);
        do_reset(1'b0);

        // Wrap: fill 14, pop 12, push 6 across the top of memory
        cycle(1'b1, 7, 64'h10, 1'b0, 0);
        cycle(1'b1, 5, 64'h18, 1'b0, 0);
        check_val("wrap_fill14", 64'(fifo_count), 64'd14);
        repeat (3) cycle(1'b0, 0, 64'd0, 1'b1, 3);
        cycle(1'b1, 5, 64'hA0, 1'b0, 0);
        check_val("wrap_count8", 64'(fifo_count), 64'd8);
`ifndef CPM_MIMO_FIFO_REG_OUT_EN
        check_val("wrap_lane0", data_out[0 +: DW], 64'h1C);
        check_val("wrap_lane2", data_out[2*DW +: DW], 64'hA0);
`endif
        cycle(1'b0, 0, 64'd0, 1'b1, 3);
        cycle(1'b0, 0, 64'd0, 1'b1, 3);
        check_val("wrap_empty", 64'(empty), 64'd1);
        do_reset(1'b0);

        // Simultaneous push and pop
        cycle(1'b1, 7, 64'h30, 1'b0, 0);
        cycle(1'b1, 1, 64'h38, 1'b0, 0);
        check_val("simul_start10", 64'(fifo_count), 64'd10);
        cycle(1'b1, 3, 64'h40, 1'b1, 1);
        check_val("simul_count12", 64'(fifo_count), 64'd12);
        cycle(1'b1, 1, 64'h44, 1'b0, 0);
        cycle(1'b1, 2, 64'h50, 1'b1, 3);
        check_val("simul_count10", 64'(fifo_count), 64'd10);
        check_val("simul_ovf", 64'(err_ovf), 64'd1);

        // Reset with push active at count 9
        cycle(1'b0, 0, 64'd0, 1'b1, 0);
        check_val("pre_reset9", 64'(fifo_count), 64'd9);
        do_reset(1'b1);
        check_val("midrst_count", 64'(fifo_count), 64'd0);
        check_val("midrst_err", 64'({err_ovf, err_udf}), 64'd0);

        // Random traffic against the queue model
        for (int n = 0; n < 10000; n++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  {32'($urandom), 32'($urandom)},
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
